// File: rtl/control_sequencer.sv
// Three-phase fetch/decode/execute sequencer for a 4-bit-operand accumulator machine.
// Drives an external asynchronous memory and an external pass/add ALU.
module control_sequencer #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic              pass_add,
    input  logic [7:0]        alu_result,
    output logic [7:0]        ac,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        StFetch,
        StDecode,
        StExecute,
        StHalt
    } state_e;

    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpOut = 4'h3;
    localparam logic [3:0] OpHlt = 4'hF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        ac_q, ac_d;
    logic              carry_q, carry_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [3:0]        opcode;
    logic [3:0]        imm;
    logic              add_carry;

    assign opcode = ir_q[7:4];
    assign imm    = ir_q[3:0];

    // Carry is the ninth bit of ac + imm, i.e. set whenever the sum exceeds 255.
    assign add_carry = ({1'b0, ac_q} + {5'b0_0000, imm}) > 9'd255;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ac_d        = ac_q;
        carry_d     = carry_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        mem_addr    = ir_q[ADDR_W-1:0];
        alu_a       = ac_q;
        alu_b       = 8'h00;
        pass_add    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_addr = pc_q;
                if (run) begin
                    ir_d    = mem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                state_d = StFetch;
                case (opcode)
                    OpLda: begin
                        alu_a = mem_data;
                        ac_d  = alu_result;
                    end
                    OpAdd: begin
                        alu_b    = {4'b0000, imm};
                        pass_add = 1'b1;
                        ac_d     = alu_result;
                        carry_d  = add_carry;
                    end
                    OpOut: begin
                        out_data_d  = ac_q;
                        out_valid_d = 1'b1;
                    end
                    OpHlt: begin
                        state_d = StHalt;
                    end
                    default: begin
                    end
                endcase
            end
            StHalt: begin
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            ir_q        <= 8'h00;
            ac_q        <= 8'h00;
            carry_q     <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ac_q        <= ac_d;
            carry_q     <= carry_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ac        = ac_q;
    assign pc        = pc_q;
    assign carry     = carry_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: behavioural instruction model with a small memory and ALU,
// directed scenarios followed by randomized programs and run/rst patterns.
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       pass_add;
    logic [7:0] alu_result;
    logic [7:0] ac;
    logic [3:0] pc;
    logic       carry;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;

    logic [7:0] mem [16];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural state plus the cycle index within an instruction.
    logic [3:0] m_pc;
    logic [7:0] m_ir;
    logic [7:0] m_ac;
    logic       m_carry;
    logic [7:0] m_out_data;
    logic       m_out_valid;
    logic       m_halt;
    int         m_cycle;

    control_sequencer #(.ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .pass_add  (pass_add),
        .alu_result(alu_result),
        .ac        (ac),
        .pc        (pc),
        .carry     (carry),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted)
    );

    assign mem_data   = mem[mem_addr];
    assign alu_result = pass_add ? alu_a + alu_b : alu_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 4'h0; m_ir = 8'h00; m_ac = 8'h00; m_carry = 1'b0;
        m_out_data = 8'h00; m_out_valid = 1'b0; m_halt = 1'b0; m_cycle = 0;
    endtask

    // One clock of the instruction-level model: an instruction spans three cycles and its
    // effect lands on the third; run only matters on the first.
    task automatic model_clock(input logic r, input logic rs);
        int sum;
        if (rs) begin
            model_reset();
        end else begin
            m_out_valid = 1'b0;
            if (!m_halt) begin
                if (m_cycle == 0) begin
                    if (r) begin
                        m_ir    = mem[m_pc];
                        m_pc    = m_pc + 4'h1;
                        m_cycle = 1;
                    end
                end else if (m_cycle == 1) begin
                    m_cycle = 2;
                end else begin
                    m_cycle = 0;
                    case (m_ir[7:4])
                        4'h1: m_ac = mem[m_ir[3:0]];
                        4'h2: begin
                            sum     = int'(m_ac) + int'(m_ir[3:0]);
                            m_carry = (sum > 255);
                            m_ac    = 8'(sum % 256);
                        end
                        4'h3: begin
                            m_out_data  = m_ac;
                            m_out_valid = 1'b1;
                        end
                        4'hF: m_halt = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic compare_all();
        logic in_fetch;
        logic adding;
        in_fetch = !m_halt && (m_cycle == 0);
        adding   = !m_halt && (m_cycle == 2) && (m_ir[7:4] == 4'h2);
        check("pc", pc, m_pc);
        check("ac", ac, m_ac);
        check("carry", carry, m_carry);
        check("out_data", out_data, m_out_data);
        check("out_valid", out_valid, m_out_valid);
        check("halted", halted, m_halt);
        check("mem_addr", mem_addr, in_fetch ? m_pc : m_ir[3:0]);
        check("pass_add", pass_add, adding);
        check("alu_b", alu_b, adding ? {4'h0, m_ir[3:0]} : 8'h00);
    endtask

    task automatic step(input logic r, input logic rs);
        run = r;
        rst = rs;
        @(posedge clk);
        model_clock(r, rs);
        #1;
        compare_all();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    initial begin
        logic       seen_out;
        logic [7:0] snap_ac;
        logic [7:0] snap_od;
        logic [3:0] snap_pc;
        logic [3:0] op;

        run = 1'b0;
        rst = 1'b1;
        clear_mem();
        model_reset();

        // Reset state
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // Reference program: LDA 8; ADD 5; OUT; HLT
        mem[0] = 8'h18; mem[1] = 8'h25; mem[2] = 8'h30; mem[3] = 8'hF0; mem[8] = 8'h07;
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        check("prog_lda_ac", ac, 8'h07);
        repeat (3) step(1'b1, 1'b0);
        check("prog_add_ac", ac, 8'h0C);
        seen_out = 1'b0;
        repeat (8) begin
            step(1'b1, 1'b0);
            if (out_valid && out_data == 8'h0C) seen_out = 1'b1;
        end
        check("prog_out_pulse", seen_out, 1'b1);
        check("prog_halted", halted, 1'b1);
        check("prog_pc", pc, 4'h4);

        // Halt ignores run
        snap_ac = ac; snap_od = out_data; snap_pc = pc;
        repeat (10) step(1'($urandom_range(0, 1)), 1'b0);
        check("halt_ac", ac, snap_ac);
        check("halt_pc", pc, snap_pc);
        check("halt_od", out_data, snap_od);
        check("halt_still", halted, 1'b1);

        // Overflow: LDA 0xFE; ADD 3; ADD 1
        clear_mem();
        mem[0] = 8'h1A; mem[1] = 8'h23; mem[2] = 8'h21; mem[3] = 8'hF0; mem[10] = 8'hFE;
        step(1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b0);
        check("ovf_ac", ac, 8'h01);
        check("ovf_carry", carry, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        check("ovf2_ac", ac, 8'h02);
        check("ovf2_carry", carry, 1'b0);

        // run low in FETCH freezes the machine
        clear_mem();
        mem[0] = 8'h25; mem[1] = 8'h23; mem[2] = 8'hF0;
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        check("stall_pc", pc, 4'h1);
        check("stall_ac", ac, 8'h05);
        repeat (3) step(1'b1, 1'b0);
        check("resume_ac", ac, 8'h08);

        // Reset in the EXECUTE cycle of an ADD
        clear_mem();
        mem[0] = 8'h18; mem[1] = 8'h22; mem[2] = 8'h23; mem[8] = 8'hFF;
        step(1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b0);
        check("pre_rst_carry", carry, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("rst_exec_ac", ac, 8'h00);
        check("rst_exec_pc", pc, 4'h0);
        check("rst_exec_carry", carry, 1'b0);
        check("rst_exec_addr", mem_addr, 4'h0);

        // NOPs and undefined opcodes wrap the program counter
        clear_mem();
        mem[5] = 8'h9A; mem[9] = 8'h4C; mem[12] = 8'hE3;
        step(1'b0, 1'b1);
        repeat (48) step(1'b1, 1'b0);
        check("wrap_pc", pc, 4'h0);
        repeat (3) step(1'b1, 1'b0);
        check("wrap_pc2", pc, 4'h1);
        check("wrap_ac", ac, 8'h00);

        // Randomized programs with random run and occasional reset
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] = 8'($urandom);
                op = mem[i][7:4];
                if (op == 4'hF && $urandom_range(0, 3) != 0) mem[i][7:4] = 4'h2;
                else if (op > 4'h3 && op != 4'hF && $urandom_range(0, 1) == 0)
                    mem[i][7:4] = 4'($urandom_range(1, 3));
            end
            step(1'b0, 1'b1);
            repeat (200) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, instruction/data memory address width; the operand field is 4 bits, so only ADDR_W=4 is supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port run, input, 1, level; allows a new instruction fetch when high.
REQ-005 SHALL have port mem_addr, output, ADDR_W, combinational address to the asynchronous-read program/data memory.
REQ-006 SHALL have port mem_data, input, 8, memory read data, valid in the same cycle as mem_addr.
REQ-007 SHALL have port alu_a, output, 8, drives the ALU A operand.
REQ-008 SHALL have port alu_b, output, 8, drives the ALU B operand.
REQ-009 SHALL have port pass_add, output, 1, ALU select: 0 = pass A, 1 = A+B.
REQ-010 SHALL have port alu_result, input, 8, ALU output bus.
REQ-011 SHALL have port ac, output, 8, accumulator register.
REQ-012 SHALL have port pc, output, ADDR_W, program counter register.
REQ-013 SHALL have port carry, output, 1, carry-out of the last ADD.
REQ-014 SHALL have port out_data, output, 8, registered copy of ac captured by OUT.
REQ-015 SHALL have port out_valid, output, 1, one-cycle pulse for each OUT.
REQ-016 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-017 SHALL decode instruction byte as opcode = bits [7:4] and operand = bits [3:0].
REQ-018 SHALL implement opcodes 0x0 NOP, 0x1 LDA addr, 0x2 ADD imm, 0x3 OUT, 0xF HLT; all other opcodes SHALL execute as NOP.
REQ-019 SHALL use four states: FETCH, DECODE, EXECUTE, HALT.
REQ-020 FETCH: mem_addr = pc; if run=1, ir <= mem_data, pc <= pc+1 (wraps 0xF->0x0), go to DECODE; if run=0, hold all state.
REQ-021 DECODE: mem_addr = ir operand; no register updates except state; go to EXECUTE.
REQ-022 EXECUTE, LDA: mem_addr = operand, alu_a = mem_data, pass_add = 0, ac <= alu_result; carry unchanged.
REQ-023 EXECUTE, ADD: alu_a = ac, alu_b = {4'b0, operand}, pass_add = 1, ac <= alu_result (mod 256).
REQ-024 EXECUTE, ADD: carry <= bit 8 of the 9-bit sum (ac + operand), computed inside the block.
REQ-025 EXECUTE, OUT: out_data <= ac; out_valid = 1 in the following cycle only.
REQ-026 EXECUTE, HLT: go to HALT. All other opcodes in EXECUTE: return to FETCH.
REQ-027 HALT: halted = 1; no state changes; leaves only via rst; run is ignored.
REQ-028 Outside EXECUTE, alu_a = ac, alu_b = 0, and pass_add = 0.
REQ-029 Each non-HLT instruction SHALL take exactly 3 cycles when run stays high; run is sampled only in FETCH.
REQ-030 In non-FETCH states, mem_addr SHALL equal the ir operand.

Reset
REQ-031 On rst=1 at a clock edge, from any state including mid-instruction, the following SHALL hold next cycle: state=FETCH, pc=0, ir=0, ac=0x00, carry=0, out_data=0x00, out_valid=0, halted=0.
REQ-032 rst SHALL take priority over run and over all state actions in the same cycle.

Verification
REQ-033 Program {0x0: 0x18, 0x1: 0x25, 0x2: 0x30, 0x3: 0xF0, 0x8: 0x07}, run=1 -> ac=0x07 after cycle 3, ac=0x0C after cycle 6, out_valid pulse with out_data=0x0C, halted=1, pc=0x4.
REQ-034 Overflow: LDA of 0xFE, then ADD 0x3 -> ac=0x01, carry=1; then ADD 0x1 -> ac=0x02, carry=0.
REQ-035 run=0 held for 5 cycles in FETCH -> pc, ac, and ir are unchanged; execution resumes on the first run=1.
REQ-036 Assert rst during the EXECUTE of an ADD -> ac=0x00, pc=0, carry=0, state FETCH next cycle; no write to ac.
REQ-037 16 NOPs with no HLT -> pc wraps 0xF -> 0x0 and fetch of address 0 repeats; undefined opcode 0x9A behaves as NOP.
REQ-038 In HALT with run toggling -> all outputs remain constant until rst.
